// File: rtl/cpu_buttons_poller_pkg.sv
// Shared types and helpers for the buttons PIO poller: FSM state encoding,
// the PIO data register address, and counter width sizing.
package cpu_buttons_poller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        EVAL = 2'd3
    } poll_state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cpu_buttons_debounce.sv
// Consecutive-sample debouncer: a new value must repeat DEBOUNCE_CNT times
// before it replaces the stable level; emits one-cycle press/release pulses.
module cpu_buttons_debounce
    import cpu_buttons_poller_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] stable,
    output logic [DATA_W-1:0] pressed_pulse,
    output logic [DATA_W-1:0] released_pulse
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

    logic [DATA_W-1:0] candidate;
    logic [DATA_W-1:0] cand_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;

    always_comb begin
        cand_next = candidate;
        cnt_next  = count;
        if (sample_valid) begin
            cand_next = sample;
            if (sample == candidate)
                cnt_next = (count == CNT_MAX) ? CNT_MAX : count + 1'b1;
            else
                cnt_next = CNT_W'(1);
        end
    end

    assign accept = sample_valid && (cnt_next == CNT_MAX) && (cand_next != stable);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            candidate      <= '0;
            count          <= '0;
            stable         <= '0;
            pressed_pulse  <= '0;
            released_pulse <= '0;
        end else begin
            candidate      <= cand_next;
            count          <= cnt_next;
            pressed_pulse  <= '0;
            released_pulse <= '0;
            if (accept) begin
                stable         <= cand_next;
                pressed_pulse  <= cand_next & ~stable;
                released_pulse <= ~cand_next & stable;
            end
        end
    end

endmodule

// File: rtl/cpu_buttons_poller.sv
// Avalon-MM read master that periodically polls the buttons PIO and debounces it.
// Optional edge-capture interrupt enabled by defining CPU_BUTTONS_POLLER_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for a pending poll from the interval timer
// REQ   | avm_read asserted, holding until the slave accepts
// WAIT  | counting read latency, then registering the sample
// EVAL  | debouncer consumes the sample, back to IDLE
module cpu_buttons_poller
    import cpu_buttons_poller_pkg::*;
#(
    parameter int DATA_W       = 4,
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int READ_LATENCY = 1,
    parameter int INVERT       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] buttons_stable,
    output logic [DATA_W-1:0] pressed_pulse,
    output logic [DATA_W-1:0] released_pulse,
    input  logic [DATA_W-1:0] irq_mask,
    input  logic [DATA_W-1:0] irq_ack,
    output logic [DATA_W-1:0] edge_capture,
    output logic              irq
);

    localparam int                DIV_W    = cnt_width(POLL_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(POLL_DIV - 1);
    localparam int                LAT_W    = cnt_width(READ_LATENCY);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LATENCY);
    localparam logic [DATA_W-1:0] INV_MASK = (INVERT != 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

    poll_state_t       state;
    logic [DIV_W-1:0]  div_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic              tc;
    logic              pending;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              unused_readdata;

    assign avm_address     = PIO_DATA_ADDR;
    assign unused_readdata = ^avm_readdata[31:DATA_W];
    assign tc              = (div_cnt == DIV_LAST);

    // Terminal counts that land while a poll is in flight merge into one pending poll.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            pending <= 1'b0;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
            if (tc)
                pending <= 1'b1;
            else if (state == IDLE)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            avm_read     <= 1'b0;
            lat_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state    <= REQ;
                        avm_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        state    <= WAIT;
                        avm_read <= 1'b0;
                        lat_cnt  <= LAT_W'(1);
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        sample       <= avm_readdata[DATA_W-1:0] ^ INV_MASK;
                        sample_valid <= 1'b1;
                        state        <= EVAL;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                EVAL: state <= IDLE;
                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

    cpu_buttons_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .sample         (sample),
        .stable         (buttons_stable),
        .pressed_pulse  (pressed_pulse),
        .released_pulse (released_pulse)
    );

`ifdef CPU_BUTTONS_POLLER_IRQ_EN
    // A new press beats a same-cycle acknowledge so no press is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~irq_ack) | pressed_pulse;
            irq          <= |(edge_capture & irq_mask);
        end
    end
`else
    logic unused_irq;
    assign unused_irq   = ^{irq_mask, irq_ack};
    assign edge_capture = '0;
    assign irq          = 1'b0;
`endif

endmodule
